// File: rtl/muldiv_iter_unit.sv
// rtl/muldiv_iter_unit.sv - iterative multiply/divide unit with start/busy/done handshake
// Shift-add multiply and restoring divide; results land in MIPS-style hi/lo.
module muldiv_iter_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 2,
  parameter int DIV_BPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int W2    = 2 * WIDTH;
  localparam int MUL_N = WIDTH / MUL_BPC;
  localparam int DIV_N = WIDTH / DIV_BPC;
  localparam int CW    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [W2-1:0]    ONE_2W = W2'(1);
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_opd;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_dz;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_dz_start;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  // Operand capture: signed ops keep magnitudes, signs go to r_neg_q / r_neg_r.
  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;
  assign w_dz_start = op[1] && (b == '0);
  assign w_a_neg    = op[0] && a[WIDTH-1];
  assign w_b_neg    = op[0] && b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (~a + ONE_W) : a;
  assign w_b_mag    = w_b_neg ? (~b + ONE_W) : b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_dz_start ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if (flush)               w_next = S_IDLE;
        else if (r_cnt == '0)    w_next = S_FIX;
      end
      S_FIX: begin
        w_next = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_next = w_dz_start ? S_FIX : S_CALC;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Multiply step: add multiplicand * low multiplier bits into the upper half, shift right.
  logic [MUL_BPC-1:0]       w_mbits;
  logic [WIDTH+MUL_BPC-1:0] w_mul_upper;
  logic [W2-1:0]            w_mul_next;

  assign w_mbits     = r_acc[MUL_BPC-1:0];
  assign w_mul_upper = {{MUL_BPC{1'b0}}, r_acc[W2-1:WIDTH]}
                     + ({{MUL_BPC{1'b0}}, r_opd} * {{WIDTH{1'b0}}, w_mbits});
  assign w_mul_next  = {w_mul_upper, r_acc[WIDTH-1:MUL_BPC]};

  // Divide step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH:0]   w_trial;
  logic [W2-1:0]    w_div_next;

  always_comb begin
    w_rem   = r_acc[W2-1:WIDTH];
    w_quo   = r_acc[WIDTH-1:0];
    w_trial = '0;
    for (int i = 0; i < DIV_BPC; i++) begin
      w_trial = {w_rem, w_quo[WIDTH-1]} - {1'b0, r_opd};
      if (!w_trial[WIDTH]) w_rem = w_trial[WIDTH-1:0];
      else                 w_rem = {w_rem[WIDTH-2:0], w_quo[WIDTH-1]};
      w_quo = {w_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    end
    w_div_next = {w_rem, w_quo};
  end

  logic [W2-1:0]    w_mul_res;
  logic [WIDTH-1:0] w_quo_res;
  logic [WIDTH-1:0] w_rem_res;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_mul_res = r_neg_q ? (~r_acc + ONE_2W) : r_acc;
  assign w_quo_res = r_neg_q ? (~r_acc[WIDTH-1:0] + ONE_W) : r_acc[WIDTH-1:0];
  assign w_rem_res = r_neg_r ? (~r_acc[W2-1:WIDTH] + ONE_W) : r_acc[W2-1:WIDTH];
  assign w_fix_hi  = r_is_div ? w_rem_res : w_mul_res[W2-1:WIDTH];
  assign w_fix_lo  = r_is_div ? w_quo_res : w_mul_res[WIDTH-1:0];

  // Divide-by-zero preloads {a, all ones} so FIX passes it straight through unsigned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_opd      <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_dz       <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else if (w_accept) begin
      r_is_div   <= op[1];
      r_dz       <= w_dz_start;
      r_div_zero <= 1'b0;
      r_neg_q    <= !w_dz_start && (w_a_neg ^ w_b_neg);
      r_neg_r    <= !w_dz_start && op[1] && w_a_neg;
      r_opd      <= op[1] ? w_b_mag : w_a_mag;
      if (w_dz_start)  r_acc <= {a, ONES_W};
      else if (op[1])  r_acc <= {{WIDTH{1'b0}}, w_a_mag};
      else             r_acc <= {{WIDTH{1'b0}}, w_b_mag};
      r_cnt      <= op[1] ? CW'(DIV_N - 1) : CW'(MUL_N - 1);
    end else if (r_state == S_CALC) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt - CW'(1);
    end else if ((r_state == S_FIX) && !flush) begin
      r_hi       <= w_fix_hi;
      r_lo       <= w_fix_lo;
      r_div_zero <= r_dz;
    end
  end

  assign busy     = (r_state == S_CALC) || (r_state == S_FIX);
  assign done     = (r_state == S_DONE);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage. It generalises the fixed 32-bit mul/div control with configurable width and configurable bits-per-cycle for each operation.
- Adds an explicit start/busy/done handshake, pipeline flush (kill), a divide-by-zero flag, and defined results for every corner case.
- Results go to the HI/LO register write-back in MIPS convention:
  - multiply: {hi,lo} = product
  - divide: hi = remainder, lo = quotient

Parameters:
- WIDTH, 32, operand and result half-width; must be even and ≥ 8.
- MUL_BPC, 2, multiplier bits retired per CALC cycle; must divide WIDTH; legal values 1, 2, 4.
- DIV_BPC, 1, quotient bits produced per CALC cycle; must divide WIDTH; legal values 1, 2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only in IDLE or DONE state
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- a  in  WIDTH  multiplicand / dividend; sampled with start
- b  in  WIDTH  multiplier / divisor; sampled with start
- flush  in  1  kill in-flight operation (exception/branch flush)
- busy  out  1  high in CALC and FIX states
- done  out  1  one-cycle pulse; hi/lo valid in that cycle
- hi  out  WIDTH  product high half / remainder
- lo  out  WIDTH  product low half / quotient
- div_zero  out  1  valid with done; 1 when a divide had b == 0

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - state = IDLE
  - busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0
  - all internal accumulators cleared
  - reset mid-operation abandons it; no done is produced.
- States IDLE, CALC, FIX, DONE:
  - IDLE --start--> CALC, or directly to FIX for a divide with b == 0.
  - CALC: iteration counter runs N-1 down to 0, with N = WIDTH/MUL_BPC for multiply and WIDTH/DIV_BPC for divide. Leaves to FIX when the counter reaches 0.
  - FIX: one cycle; sign correction and result latch; goes to DONE.
  - DONE: done = 1 for exactly this cycle; then IDLE, or CALC/FIX if start is present (back-to-back acceptance).
- Latency: done is asserted exactly N+2 cycles after the start cycle.
  - Defaults: MULT/MULTU = 18, DIV/DIVU = 34.
  - Divide by zero = 2.
- Operand capture:
  - Signed ops register the magnitudes |a| and |b| plus the result sign.
  - Signed divide also registers the dividend sign.
  - Unsigned ops register the operands unchanged.
  - Inputs are don't-care after the start cycle.
- Multiply:
  - Shift-add, consuming MUL_BPC multiplier bits per cycle into a 2*WIDTH accumulator.
  - FIX two's-complement negates the accumulator if the sign bit is set.
  - Result is exact modulo 2^(2*WIDTH).
- Divide:
  - Restoring division, DIV_BPC quotient bits per cycle.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed MIN / -1 gives lo = MIN, hi = 0, no flag.
- Divide by zero (b == 0, DIV or DIVU):
  - lo = all ones, hi = a (raw, unsigned view)
  - div_zero = 1 in the done cycle
  - multiply never sets div_zero.
- hi/lo update only in FIX. They hold their value from one done until the next FIX; flush does not alter them.
- div_zero is cleared when the next operation is accepted.
- start while busy is ignored and has no side effects.
- Flush:
  - flush high in CALC or FIX: next state is IDLE, no done, hi/lo unchanged.
  - flush in DONE: done still pulses in that cycle, next state is IDLE.
  - flush and start in the same cycle: flush wins, start is dropped.
- rst has priority over flush; flush has priority over start.
- busy is a registered decode of state, with no combinational path from start. The EX stage stalls on busy | (start accepted this cycle).

Test Plan:
- Reset held 2 cycles mid-divide: hi = lo = 0, busy = 0, no done afterward.
- MULT, a = 0xFFFFFFFE (-2), b = 0x00000003: done at cycle 18, {hi,lo} = 0xFFFFFFFF_FFFFFFFA. MULTU with the same operands: {hi,lo} = 0x00000002_FFFFFFFA.
- DIV, a = 0xFFFFFFF9 (-7), b = 2: done at cycle 34, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- DIVU, a = 0x12345678, b = 0: done at cycle 2, div_zero = 1, lo = 0xFFFFFFFF, hi = 0x12345678.
- Flush at CALC cycle 5 of a MULTU, then start DIVU 100/7 in the next cycle:
  - no done for the flushed operation; hi/lo keep their prior values
  - DIVU done 34 cycles later with lo = 14, hi = 2.
- Back-to-back, plus parameter sweep:
  - start held high in the DONE cycle starts the next operation; second done is exactly N+2 cycles later.
  - repeat with WIDTH = 16, MUL_BPC = 4 (latency 6) and DIV_BPC = 2 (latency 10) against a reference model, 10k random operands.
